// File: rtl/ifetch_unit.sv
// Instruction fetch stage: holds the fetch PC, issues one-outstanding imem requests, hands instr/pc to the decoder.
// Latency: 3 cycles per instruction best case (request/grant, rvalid, instr_valid); imem_req/imem_addr are registered.
// Backpressure: instr_valid holds instr/pc stable until instr_ready; no new request is issued while holding.
// Optional build macro IFETCH_STALL_CNT_EN adds a saturating 32-bit stall_cnt output.

module ifetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
`ifdef IFETCH_STALL_CNT_EN
    ,
    output logic [31:0]     stall_cnt
`endif
);

    // FETCH: request in flight on the bus; WAIT: granted, awaiting data;
    // HOLD: instruction presented to decoder; DROP: granted request was flushed,
    // its data must be swallowed before a new request can go out.
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        DROP  = 2'd3
    } state_t;

    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
    localparam logic [XLEN-1:0] BOOT_PC    = RESET_PC & ALIGN_MASK;

    state_t          state;
    state_t          state_nxt;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] fetch_pc_nxt;
    logic [XLEN-1:0] redirect_target;
    logic            req_q;
    logic [XLEN-1:0] addr_q;
    logic            valid_q;
    logic [31:0]     instr_q;
    logic [XLEN-1:0] pc_q;
    logic            gnt_eff;
    logic            load_instr;

    // Redirect targets are always word aligned regardless of the low bits supplied.
    assign redirect_target = redirect_pc & ALIGN_MASK;

    // A grant only counts while our request is actually on the bus; the first
    // FETCH cycle after reset has imem_req low and must not see a grant.
    assign gnt_eff = imem_gnt & req_q;

    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign instr_valid = valid_q;
    assign instr       = instr_q;
    assign pc          = pc_q;

    // Next-state and fetch-PC selection; redirect outranks every other event.
    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        load_instr   = 1'b0;
        case (state)
            FETCH: begin
                if (redirect_valid) begin
                    fetch_pc_nxt = redirect_target;
                    // Old address already accepted by memory: its data must be dropped.
                    if (gnt_eff) begin
                        state_nxt = DROP;
                    end
                end else if (gnt_eff) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    fetch_pc_nxt = redirect_target;
                    // Data arriving with the redirect is stale; otherwise wait it out in DROP.
                    state_nxt    = imem_rvalid ? FETCH : DROP;
                end else if (imem_rvalid) begin
                    load_instr = 1'b1;
                    state_nxt  = HOLD;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    // A concurrent instr_ready still retires the held word, but the
                    // next fetch goes to the target rather than the sequential PC.
                    fetch_pc_nxt = redirect_target;
                    state_nxt    = FETCH;
                end else if (instr_ready) begin
                    fetch_pc_nxt = fetch_pc + PC_STEP;
                    state_nxt    = FETCH;
                end
            end
            DROP: begin
                if (redirect_valid) begin
                    fetch_pc_nxt = redirect_target;
                end
                if (imem_rvalid) begin
                    state_nxt = FETCH;
                end
            end
            default: begin
                state_nxt = FETCH;
            end
        endcase
    end

    // State, fetch PC and registered bus/decoder outputs; reset overrides any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FETCH;
            fetch_pc <= BOOT_PC;
            req_q    <= 1'b0;
            addr_q   <= BOOT_PC;
            valid_q  <= 1'b0;
            instr_q  <= 32'h0;
            pc_q     <= BOOT_PC;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
            // Request/address are registered from the next state so they line up with FETCH.
            req_q    <= (state_nxt == FETCH);
            addr_q   <= fetch_pc_nxt;
            valid_q  <= (state_nxt == HOLD);
            if (load_instr) begin
                instr_q <= imem_rdata;
                pc_q    <= fetch_pc;
            end
        end
    end

`ifdef IFETCH_STALL_CNT_EN
    logic [31:0] stall_q;

    // Counts cycles the decoder is starved of a valid instruction, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= 32'h0;
        end else if (!valid_q && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'h1;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed scenarios plus a transaction-level
// model tracking the architectural next PC, the single outstanding request and
// the expected instruction word for every valid cycle.
module tb_ifetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] DATA_K = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
`ifdef IFETCH_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    ifetch_unit #(.XLEN(32), .RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .pc             (pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
`ifdef IFETCH_STALL_CNT_EN
        ,
        .stall_cnt      (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    // Memory responder state
    int          rv_delay = 1;
    bit          g_seen   = 1'b0;
    logic [31:0] g_addr   = 32'h0;
    int          rv_cnt   = 0;
    logic [31:0] rv_dat   = 32'h0;

    // Model state
    logic [31:0] arch_pc = RST_PC;
    bit          outst   = 1'b0;
    logic [31:0] req_log[$];
    logic [31:0] del_log[$];
    int          del_cyc[$];

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 20; i++) begin
            if (instr_valid) break;
            step(1);
        end
        chk(instr_valid == 1'b1, "wait_valid", {31'h0, instr_valid}, 32'h1);
    endtask

    task automatic chk_out(input string name, input logic v, input logic r,
                           input logic [31:0] a_exp, input bit chk_a);
        chk(instr_valid == v, {name, "_valid"}, {31'h0, instr_valid}, {31'h0, v});
        chk(imem_req == r, {name, "_req"}, {31'h0, imem_req}, {31'h0, r});
        if (chk_a) chk(imem_addr == a_exp, {name, "_addr"}, imem_addr, a_exp);
    endtask

    task automatic chk_instr(input string name, input logic [31:0] p, input logic [31:0] w);
        chk(pc == p, {name, "_pc"}, pc, p);
        chk(instr == w, {name, "_instr"}, instr, w);
    endtask

    // Memory: returns addr+0x13 rv_delay cycles after each grant.
    initial begin
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        forever begin
            @(posedge clk);
            #2;
            imem_rvalid = 1'b0;
            if (g_seen) begin
                rv_cnt = rv_delay;
                rv_dat = g_addr + DATA_K;
                g_seen = 1'b0;
            end
            if (rv_cnt > 0) begin
                rv_cnt--;
                if (rv_cnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = rv_dat;
                end
            end
        end
    end

    // Compare process: transaction model checked every cycle on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                arch_pc = RST_PC;
                outst   = 1'b0;
            end else begin
                if (imem_req) begin
                    chk(imem_addr[1:0] == 2'b00, "addr_align", imem_addr, imem_addr & ~32'h3);
                    chk(outst == 1'b0, "one_outstanding", {31'h0, outst}, 32'h0);
                end
                if (instr_valid) begin
                    chk(pc == arch_pc, "model_pc", pc, arch_pc);
                    chk(instr == arch_pc + DATA_K, "model_instr", instr, arch_pc + DATA_K);
                end
                if (imem_req && imem_gnt) begin
                    chk(imem_addr == arch_pc, "model_req_addr", imem_addr, arch_pc);
                    req_log.push_back(imem_addr);
                    g_addr = imem_addr;
                    g_seen = 1'b1;
                end
                if (imem_rvalid) outst = 1'b0;
                if (imem_req && imem_gnt) outst = 1'b1;
                if (instr_valid && instr_ready) begin
                    del_log.push_back(pc);
                    del_cyc.push_back(cyc);
                end
                if (redirect_valid) arch_pc = redirect_pc & ~32'h3;
                else if (instr_valid && instr_ready) arch_pc = arch_pc + 32'h4;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        imem_gnt       = 1'b1;
        instr_ready    = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        step(1);
        rst = 1'b0;

        // Reset state
        chk_out("reset", 1'b0, 1'b0, RST_PC, 1'b1);
        chk_instr("reset", RST_PC, 32'h0);

        // Streaming: addresses 0,4,8, one delivery every 3 cycles
        step(10);
        chk(req_log.size() >= 3, "stream_req_count", req_log.size(), 3);
        chk(del_log.size() >= 3, "stream_del_count", del_log.size(), 3);
        if (req_log.size() >= 3 && del_log.size() >= 3) begin
            for (int i = 0; i < 3; i++) begin
                chk(req_log[i] == 32'(4 * i), "stream_req_addr", req_log[i], 32'(4 * i));
                chk(del_log[i] == 32'(4 * i), "stream_del_pc", del_log[i], 32'(4 * i));
            end
            chk(del_cyc[1] - del_cyc[0] == 3, "stream_spacing", del_cyc[1] - del_cyc[0], 3);
            chk(del_cyc[2] - del_cyc[1] == 3, "stream_spacing2", del_cyc[2] - del_cyc[1], 3);
        end

        // Backpressure on pc 0xC
        instr_ready = 1'b0;
        wait_valid();
        chk_instr("bp_first", 32'h0000_000C, 32'h0000_001F);
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk_out("bp_hold", 1'b1, 1'b0, 32'h0, 1'b0);
            chk_instr("bp_hold", 32'h0000_000C, 32'h0000_001F);
        end
        instr_ready = 1'b1;
        step(1);
        chk_out("bp_release", 1'b0, 1'b1, 32'h0000_0010, 1'b1);

        // Redirect in WAIT (data not yet back) to 0x103
        rv_delay = 2;
        step(1);
        chk_out("rdw_wait", 1'b0, 1'b0, 32'h0, 1'b0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        step(1);
        redirect_valid = 1'b0;
        chk_out("rdw_drop", 1'b0, 1'b0, 32'h0, 1'b0);
        rv_delay = 1;
        step(1);
        chk_out("rdw_fetch", 1'b0, 1'b1, 32'h0000_0100, 1'b1);
        wait_valid();
        chk_instr("rdw_deliver", 32'h0000_0100, 32'h0000_0113);

        // Redirect coincident with rvalid in WAIT
        step(2);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        step(1);
        redirect_valid = 1'b0;
        chk_out("rdrv_fetch", 1'b0, 1'b1, 32'h0000_0200, 1'b1);
        wait_valid();
        chk_instr("rdrv_deliver", 32'h0000_0200, 32'h0000_0213);

        // Redirect coincident with instr_ready in HOLD
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0300;
        step(1);
        redirect_valid = 1'b0;
        chk_out("rdh_fetch", 1'b0, 1'b1, 32'h0000_0300, 1'b1);
        wait_valid();
        chk_instr("rdh_deliver", 32'h0000_0300, 32'h0000_0313);

        // Grant held low 4 cycles with a redirect to the top word, then wrap
        imem_gnt = 1'b0;
        step(1);
        for (int i = 0; i < 4; i++) begin
            chk_out("gntlow", 1'b0, 1'b1, (i == 0) ? 32'h0000_0304 : 32'hFFFF_FFFC, 1'b1);
            if (i == 0) begin
                redirect_valid = 1'b1;
                redirect_pc    = 32'hFFFF_FFFE;
            end else begin
                redirect_valid = 1'b0;
            end
            step(1);
        end
        imem_gnt = 1'b1;
        chk_out("gnt_return", 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
        wait_valid();
        chk_instr("wrap_deliver", 32'hFFFF_FFFC, 32'h0000_000F);
        step(1);
        chk_out("wrap_fetch", 1'b0, 1'b1, 32'h0000_0000, 1'b1);

        // Reset in WAIT, with stale data landing just after reset
        rv_delay = 2;
        step(1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk_out("rstw", 1'b0, 1'b0, 32'h0, 1'b0);
        chk_instr("rstw", RST_PC, 32'h0);
        rv_delay = 1;
        step(1);
        chk_out("rstw_fetch", 1'b0, 1'b1, RST_PC, 1'b1);
        wait_valid();
        chk_instr("rstw_deliver", RST_PC, RST_PC + DATA_K);

        // Reset in HOLD
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk_out("rsth", 1'b0, 1'b0, 32'h0, 1'b0);
        chk_instr("rsth", RST_PC, 32'h0);
        step(1);
        chk_out("rsth_fetch", 1'b0, 1'b1, RST_PC, 1'b1);
        wait_valid();
        chk_instr("rsth_deliver", RST_PC, RST_PC + DATA_K);
        step(3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
